// File: rtl/shared_dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter: default sizes,
// port identifiers and the saturating counter helper.
package shared_dmem_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 64;
    localparam int ADDR_W     = 32;
    localparam int CNT_W      = 16;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/shared_dmem_arbiter_if.sv
// Bundle of the two processing-element request/response channels plus the
// conflict counter; master = PE side, slave = arbiter side.
interface shared_dmem_arbiter_if
    import shared_dmem_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [CNT_W-1:0]  conflict_cnt;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, conflict_cnt
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, conflict_cnt
    );

endinterface

// File: rtl/shared_dmem_array.sv
// Word storage: one write port, one registered read port, whole array cleared
// by the asynchronous reset.
module shared_dmem_array
    import shared_dmem_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_W-1:0]        i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_W-1:0]        o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: clearing every word on reset turns the array into plain flops (no RAM
    // macro); that is deliberate since reads after reset must return zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/shared_dmem_arbiter.sv
// Two-PE shared data memory: round-robin grant, single-cycle access,
// per-port read-response steering and a saturating conflict counter.
module shared_dmem_arbiter
    import shared_dmem_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    shared_dmem_arbiter_if.slave  io_bus
);

    localparam int IDX_W = $clog2(DEPTH);

    port_id_e          r_last_gnt;
    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [DATA_W-1:0] r_rdata0_hold;
    logic [DATA_W-1:0] r_rdata1_hold;
    logic [CNT_W-1:0]  r_conflict_cnt;

    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any_gnt;
    logic              w_conflict;
    port_id_e          w_sel;
    logic              w_sel_we;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [IDX_W-1:0]  w_idx0;
    logic [IDX_W-1:0]  w_idx1;
    logic [DATA_W-1:0] w_array_rdata;

    // Byte address to word index; high bits alias, low two bits are ignored.
    assign w_idx0     = io_bus.addr0[IDX_W+1:2];
    assign w_idx1     = io_bus.addr1[IDX_W+1:2];
    assign w_conflict = io_bus.req0 & io_bus.req1;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (rst) begin
            if (io_bus.req0 && (!io_bus.req1 || r_last_gnt == PORT1)) begin
                w_gnt0 = 1'b1;
            end else if (io_bus.req1) begin
                w_gnt1 = 1'b1;
            end
        end
    end

    assign w_any_gnt = w_gnt0 | w_gnt1;

    always_comb begin
        w_sel       = PORT0;
        w_sel_we    = io_bus.we0;
        w_sel_idx   = w_idx0;
        w_sel_wdata = io_bus.wdata0;
        if (w_gnt1) begin
            w_sel       = PORT1;
            w_sel_we    = io_bus.we1;
            w_sel_idx   = w_idx1;
            w_sel_wdata = io_bus.wdata1;
        end
    end

    assign w_wr_en = w_any_gnt & w_sel_we;
    assign w_rd_en = w_any_gnt & ~w_sel_we;

    shared_dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_wr_en),
        .i_waddr (w_sel_idx),
        .i_wdata (w_sel_wdata),
        .i_re    (w_rd_en),
        .i_raddr (w_sel_idx),
        .o_rdata (w_array_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_gnt     <= PORT1;
            r_rvalid0      <= 1'b0;
            r_rvalid1      <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_any_gnt) begin
                r_last_gnt <= w_sel;
            end
            r_rvalid0 <= w_gnt0 & ~io_bus.we0;
            r_rvalid1 <= w_gnt1 & ~io_bus.we1;
            if (w_conflict) begin
                r_conflict_cnt <= sat_inc(r_conflict_cnt);
            end
        end
    end

    // The array's read register is shared, so each port keeps its own copy of
    // the last word it received for the cycles where it has no response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata0_hold <= '0;
            r_rdata1_hold <= '0;
        end else begin
            if (r_rvalid0) begin
                r_rdata0_hold <= w_array_rdata;
            end
            if (r_rvalid1) begin
                r_rdata1_hold <= w_array_rdata;
            end
        end
    end

    assign io_bus.gnt0         = w_gnt0;
    assign io_bus.gnt1         = w_gnt1;
    assign io_bus.rvalid0      = r_rvalid0;
    assign io_bus.rvalid1      = r_rvalid1;
    assign io_bus.rdata0       = r_rvalid0 ? w_array_rdata : r_rdata0_hold;
    assign io_bus.rdata1       = r_rvalid1 ? w_array_rdata : r_rdata1_hold;
    assign io_bus.conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// Directed and randomized bench for shared_dmem_arbiter, checked against a
// transaction-level model of the memory, round-robin pointer and counter.
module tb_shared_dmem_arbiter;
    import shared_dmem_arbiter_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    shared_dmem_arbiter_if #(.DATA_W(DW)) bus ();

    shared_dmem_arbiter #(
        .DATA_W (DW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    typedef struct {
        bit          req;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } pe_req_t;

    pe_req_t     pe [2];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] m_mem [DEPTH];
    int          m_last;
    int          m_cnt;
    bit          m_rv [2];
    logic [31:0] m_rd [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_last = 1;
        m_cnt  = 0;
        for (int p = 0; p < 2; p++) begin
            m_rv[p] = 1'b0;
            m_rd[p] = '0;
        end
    endtask

    task automatic set_req(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
        pe[p].req   = 1'b1;
        pe[p].we    = we;
        pe[p].addr  = a;
        pe[p].wdata = d;
    endtask

    task automatic drive();
        bus.req0   = pe[0].req;
        bus.we0    = pe[0].we;
        bus.addr0  = pe[0].addr;
        bus.wdata0 = pe[0].wdata;
        bus.req1   = pe[1].req;
        bus.we1    = pe[1].we;
        bus.addr1  = pe[1].addr;
        bus.wdata1 = pe[1].wdata;
    endtask

    // One bus cycle: drive, check at the falling edge, then advance the model.
    task automatic do_cycle(input bit chk, output int gp);
        int exp_g;
        bit both;
        drive();
        @(negedge clk);
        both = pe[0].req && pe[1].req;
        if (both)           exp_g = 1 - m_last;
        else if (pe[0].req) exp_g = 0;
        else if (pe[1].req) exp_g = 1;
        else                exp_g = -1;
        if (chk) begin
            check("gnt0", 32'(bus.gnt0), 32'(exp_g == 0));
            check("gnt1", 32'(bus.gnt1), 32'(exp_g == 1));
            check("rvalid0", 32'(bus.rvalid0), 32'(m_rv[0]));
            check("rvalid1", 32'(bus.rvalid1), 32'(m_rv[1]));
            check("rdata0", bus.rdata0, m_rd[0]);
            check("rdata1", bus.rdata1, m_rd[1]);
            check("conflict_cnt", 32'(bus.conflict_cnt), 32'(m_cnt));
        end
        gp = bus.gnt0 ? 0 : (bus.gnt1 ? 1 : -1);
        @(posedge clk);
        m_rv[0] = 1'b0;
        m_rv[1] = 1'b0;
        if (exp_g >= 0) begin
            if (pe[exp_g].we) begin
                m_mem[word_of(pe[exp_g].addr)] = pe[exp_g].wdata;
            end else begin
                m_rv[exp_g] = 1'b1;
                m_rd[exp_g] = m_mem[word_of(pe[exp_g].addr)];
            end
            m_last = exp_g;
            pe[exp_g].req = 1'b0;
        end
        if (both) m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        #1;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gp;
        int g [4];

        for (int p = 0; p < 2; p++) begin
            pe[p].req = 1'b0; pe[p].we = 1'b0; pe[p].addr = '0; pe[p].wdata = '0;
        end
        model_reset();

        // Reset held with both PEs requesting.
        set_req(0, 1'b0, 32'h10, '0);
        set_req(1, 1'b0, 32'h40, '0);
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_gnt0", 32'(bus.gnt0), 32'd0);
        check("rst_gnt1", 32'(bus.gnt1), 32'd0);
        check("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
        check("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
        check("rst_cnt", 32'(bus.conflict_cnt), 32'd0);
        check("rst_rdata0", bus.rdata0, 32'd0);
        @(posedge clk);
        #1;
        pe[1].req = 1'b0;
        rst = 1'b1;
        do_cycle(1'b1, gp);
        check("first_gnt_after_rst", 32'(gp), 32'd0);
        do_cycle(1'b1, gp);

        // Write then read back-to-back on PE0.
        set_req(0, 1'b1, 32'h08, 32'hDEADBEEF);
        do_cycle(1'b1, gp);
        check("wr08_gnt", 32'(gp), 32'd0);
        set_req(0, 1'b0, 32'h08, '0);
        do_cycle(1'b1, gp);
        check("rd08_gnt", 32'(gp), 32'd0);
        do_cycle(1'b1, gp);
        check("rd08_data_hold", bus.rdata0, 32'hDEADBEEF);

        // PE1 writes an aliasing address, which also moves the pointer to PE1.
        set_req(1, 1'b1, 32'h104, 32'h11);
        do_cycle(1'b1, gp);

        // Four conflict cycles with both PEs re-requesting immediately.
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < 2; p++)
                if (!pe[p].req) set_req(p, 1'b0, 32'h200 + 32'(4 * k), '0);
            do_cycle(1'b1, gp);
            g[k] = gp;
        end
        check("conf_g0", 32'(g[0]), 32'd0);
        check("conf_g1", 32'(g[1]), 32'd1);
        check("conf_g2", 32'(g[2]), 32'd0);
        check("conf_g3", 32'(g[3]), 32'd1);
        do_cycle(1'b1, gp);
        check("conf_cnt4", 32'(bus.conflict_cnt), 32'd4);

        // Alias read of word 1 through a different byte address.
        set_req(0, 1'b0, 32'h004, '0);
        do_cycle(1'b1, gp);
        do_cycle(1'b1, gp);
        check("alias_rdata0", bus.rdata0, 32'h11);

        // Same-address write race with the pointer on PE1.
        set_req(1, 1'b0, 32'h0, '0);
        do_cycle(1'b1, gp);
        set_req(0, 1'b1, 32'h20, 32'hA);
        set_req(1, 1'b1, 32'h20, 32'hB);
        do_cycle(1'b1, gp);
        check("race_first", 32'(gp), 32'd0);
        do_cycle(1'b1, gp);
        check("race_second", 32'(gp), 32'd1);
        set_req(0, 1'b0, 32'h20, '0);
        do_cycle(1'b1, gp);
        do_cycle(1'b1, gp);
        check("race_rdata0", bus.rdata0, 32'hB);

        // Randomized traffic with requests held until granted.
        repeat (400) begin
            for (int p = 0; p < 2; p++)
                if (!pe[p].req && $urandom_range(0, 2) != 0)
                    set_req(p, 1'($urandom_range(0, 1)), $urandom, $urandom);
            do_cycle(1'b1, gp);
        end
        repeat (3) do_cycle(1'b1, gp);

        // Reset asserted during a granted read aborts the response.
        set_req(0, 1'b0, 32'h08, '0);
        drive();
        @(negedge clk);
        check("midrd_gnt0", 32'(bus.gnt0), 32'd1);
        #2;
        rst = 1'b0;
        @(posedge clk);
        pe[0].req = 1'b0;
        drive();
        model_reset();
        @(negedge clk);
        check("midrd_rvalid0", 32'(bus.rvalid0), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        do_cycle(1'b1, gp);
        check("midrd_rvalid0_after", 32'(bus.rvalid0), 32'd0);
        set_req(0, 1'b0, 32'h08, '0);
        do_cycle(1'b1, gp);
        do_cycle(1'b1, gp);
        check("mem_cleared", bus.rdata0, 32'd0);

        // Drive the conflict counter to saturation.
        repeat (65534) begin
            for (int p = 0; p < 2; p++)
                if (!pe[p].req) set_req(p, 1'b0, 32'($urandom_range(0, 255)), '0);
            do_cycle(1'b0, gp);
        end
        repeat (4) begin
            for (int p = 0; p < 2; p++)
                if (!pe[p].req) set_req(p, 1'b0, 32'($urandom_range(0, 255)), '0);
            do_cycle(1'b1, gp);
        end
        check("cnt_saturated", 32'(bus.conflict_cnt), 32'hFFFF);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule

// File: doc/shared_dmem_arbiter.md
SHARED_DMEM_ARBITER -- requirements
Module: shared_dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, data word width.
REQ-002 The block SHALL have parameter DEPTH, default 64, number of memory words (power of two).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports req0/req1, input, 1, access request from PE0/PE1.
REQ-006 The block SHALL have ports we0/we1, input, 1, 1 = write, 0 = read.
REQ-007 The block SHALL have ports addr0/addr1, input, 32, byte address.
REQ-008 The block SHALL have ports wdata0/wdata1, input, DATA_W, write data.
REQ-009 The block SHALL have ports gnt0/gnt1, output, 1, combinational grant in the current cycle.
REQ-010 The block SHALL have ports rvalid0/rvalid1, output, 1, read-data valid, registered.
REQ-011 The block SHALL have ports rdata0/rdata1, output, DATA_W, read data, registered.
REQ-012 The block SHALL have port conflict_cnt, output, 16, count of cycles with req0 and req1 both high.

Function
REQ-013 Word index SHALL be addr[log2(DEPTH)+1:2]; addr[1:0] and upper bits ignored (aliasing/wrap, no error).
REQ-014 At most one of gnt0/gnt1 SHALL be high per cycle; a grant SHALL only be given to an asserted req.
REQ-015 Single requester: it SHALL be granted in the same cycle.
REQ-016 Both requesting: round-robin; grant the port not served by the most recent grant (pointer last_gnt).
REQ-017 last_gnt SHALL update only on a cycle where a grant occurs; idle cycles leave it unchanged.
REQ-018 Granted write: mem[idx] <= wdata at the rising edge ending the grant cycle.
REQ-019 Granted read: rvalidN = 1 and rdataN = mem[idx] in the cycle after the grant (latency 1); rvalidN = 0 otherwise.
REQ-020 rdataN SHALL hold its last value when rvalidN = 0.
REQ-021 Requester protocol: req, we, addr, wdata held stable until gnt seen; ungranted requests are not queued inside the block.
REQ-022 Back-to-back grants to the same port on consecutive cycles SHALL be allowed when the other port is idle.
REQ-023 Read of an address written in the previous cycle SHALL return the new data (write then read, no bypass needed since latency 1).
REQ-024 conflict_cnt SHALL increment by 1 per cycle with req0 & req1, saturating at 16'hFFFF.

Reset
REQ-025 While rst = 0: gnt0 = gnt1 = 0 regardless of req, rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0, conflict_cnt = 0, last_gnt = 1 (PE0 wins first conflict), all memory words = 0.
REQ-026 Reset asserted mid-access SHALL abort it: a pending read yields no rvalid; a write in that cycle is not committed.
REQ-027 First grant after release SHALL be possible in the first cycle with rst = 1.

Structure
REQ-028 DEPTH, DATA_W defaults and the arbiter port-id encoding (PORT0 = 0, PORT1 = 1) SHALL live in a shared package.
REQ-029 Storage SHALL be a sub-module shared_dmem_array (one write port, one synchronous read port, async clear); arbitration, pointer, response steering and counter in the top.

Verification
REQ-030 Reset: rst low with req0 = 1 -> gnt0 = 0, rvalid = 0, conflict_cnt = 0; read addr 0x10 after release -> rdata0 = 0 next cycle.
REQ-031 Single write/read: PE0 writes 0xDEADBEEF to 0x08, then reads 0x08 -> gnt0 each cycle, rvalid0 = 1 with 0xDEADBEEF one cycle after read grant.
REQ-032 Conflict: req0 = req1 = 1 for 4 cycles -> grants 0,1,0,1; conflict_cnt = 4.
REQ-033 Alias: PE1 writes 0x11 to 0x104 (DEPTH 64), PE0 reads 0x004 -> rdata0 = 0x11.
REQ-034 Same-address race: both write 0x20 (PE0 0xA, PE1 0xB) with last_gnt = 1 -> PE0 first, PE1 second; later read returns 0xB.
REQ-035 Reset mid-read: grant read, assert rst before next edge -> rvalid0 stays 0; conflict_cnt saturation forced near 0xFFFF holds at 0xFFFF.
